// File: rtl/reg_bus_adapter_pkg.sv
// -----------------------------------------------------------------------------
// reg_bus_adapter_pkg
//   Shared types and helpers for the register bus adapter and its
//   address checker.
//
//   Contents:
//     rba_state_e : adapter FSM states (IDLE, ACCESS, RESP)
//     be_width()  : byte-enable width for a given data width (DW/8)
// -----------------------------------------------------------------------------
package reg_bus_adapter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } rba_state_e;

    function automatic int be_width(input int dw);
        return dw / 8;
    endfunction

endpackage

// File: rtl/reg_addr_check.sv
// -----------------------------------------------------------------------------
// reg_addr_check
//   Purely combinational decode check for one register access. Flags an
//   access that the register file must never see.
//
//   Ports:
//     addr       in  AW        byte address of the access
//     write      in  1         1 = write, 0 = read
//     be         in  DW/8      byte enables of the access
//     decode_err out 1         misaligned, out of range, or partial write
//                              (the latter only when FullWriteOnly is set)
// -----------------------------------------------------------------------------
module reg_addr_check
    import reg_bus_adapter_pkg::*;
#(
    parameter int AW            = 8,
    parameter int DW            = 32,
    parameter int NumRegs       = 16,
    parameter bit FullWriteOnly = 1'b1
) (
    input  logic [AW-1:0]            addr,
    input  logic                     write,
    input  logic [be_width(DW)-1:0]  be,
    output logic                     decode_err
);

    // One extra bit so that a limit equal to 2**AW still compares correctly.
    localparam logic [AW:0] AddrLimit = (AW+1)'(4 * NumRegs);

    logic misaligned;
    logic out_of_range;
    logic partial_write;

    assign misaligned    = |addr[1:0];
    assign out_of_range  = ({1'b0, addr} >= AddrLimit);
    assign partial_write = FullWriteOnly && write && (be != '1);
    assign decode_err    = misaligned | out_of_range | partial_write;

endmodule

// File: rtl/reg_bus_adapter.sv
// -----------------------------------------------------------------------------
// reg_bus_adapter
//   Bus-side front end of a register block. Turns a valid/ready
//   request/response bus into single-cycle write/read strobes for the
//   register file and returns read data or an error on a buffered response.
//   Exactly one access is in flight at a time (minimum 3 cycles per access).
//
//   Ports:
//     clk_i, rst_ni           clock, async active-low reset
//     req_valid_i/ready_o     request handshake
//     req_write_i             1 = write, 0 = read
//     req_addr_i/wdata_i/be_i request address, write data, byte enables
//     rsp_valid_o/ready_i     response handshake
//     rsp_rdata_o             read data (0 for writes and errors)
//     rsp_error_o             access error (decode or register file)
//     reg_we_o / reg_re_o     one-cycle write / read strobes
//     reg_addr_o/wdata_o/be_o captured request fields
//     reg_rdata_i             combinational read data for reg_addr_o
//     reg_error_i             register-file error for reg_addr_o
// -----------------------------------------------------------------------------
module reg_bus_adapter
    import reg_bus_adapter_pkg::*;
#(
    parameter int AW            = 8,
    parameter int DW            = 32,
    parameter int NumRegs       = 16,
    parameter bit FullWriteOnly = 1'b1
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     req_valid_i,
    output logic                     req_ready_o,
    input  logic                     req_write_i,
    input  logic [AW-1:0]            req_addr_i,
    input  logic [DW-1:0]            req_wdata_i,
    input  logic [be_width(DW)-1:0]  req_be_i,
    output logic                     rsp_valid_o,
    input  logic                     rsp_ready_i,
    output logic [DW-1:0]            rsp_rdata_o,
    output logic                     rsp_error_o,
    output logic                     reg_we_o,
    output logic                     reg_re_o,
    output logic [AW-1:0]            reg_addr_o,
    output logic [DW-1:0]            reg_wdata_o,
    output logic [be_width(DW)-1:0]  reg_be_o,
    input  logic [DW-1:0]            reg_rdata_i,
    input  logic                     reg_error_i
);

    rba_state_e state;
    rba_state_e state_next;
    logic       captured_write;
    logic       decode_err;

    // The check runs on the captured fields, so decode_err is stable for the
    // whole ACCESS cycle without needing a flop of its own.
    reg_addr_check #(
        .AW            (AW),
        .DW            (DW),
        .NumRegs       (NumRegs),
        .FullWriteOnly (FullWriteOnly)
    ) u_addr_check (
        .addr       (reg_addr_o),
        .write      (captured_write),
        .be         (reg_be_o),
        .decode_err (decode_err)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Strobes are decoded from the state so an async reset kills them at once.
    always_comb begin
        state_next  = state;
        req_ready_o = 1'b0;
        rsp_valid_o = 1'b0;
        reg_we_o    = 1'b0;
        reg_re_o    = 1'b0;
        unique case (state)
            IDLE: begin
                req_ready_o = 1'b1;
                if (req_valid_i) begin
                    state_next = ACCESS;
                end
            end
            ACCESS: begin
                reg_we_o   = captured_write  && !decode_err;
                reg_re_o   = !captured_write && !decode_err;
                state_next = RESP;
            end
            RESP: begin
                rsp_valid_o = 1'b1;
                if (rsp_ready_i) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Request fields are captured only on the request handshake; the response
    // is captured at the end of ACCESS and then held through RESP.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            captured_write <= 1'b0;
            reg_addr_o     <= '0;
            reg_wdata_o    <= '0;
            reg_be_o       <= '0;
            rsp_rdata_o    <= '0;
            rsp_error_o    <= 1'b0;
        end else begin
            if (state == IDLE && req_valid_i) begin
                captured_write <= req_write_i;
                reg_addr_o     <= req_addr_i;
                reg_wdata_o    <= req_wdata_i;
                reg_be_o       <= req_be_i;
            end
            if (state == ACCESS) begin
                rsp_error_o <= decode_err | reg_error_i;
                if (!captured_write && !decode_err && !reg_error_i) begin
                    rsp_rdata_o <= reg_rdata_i;
                end else begin
                    rsp_rdata_o <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_reg_bus_adapter.sv
// -----------------------------------------------------------------------------
// tb_reg_bus_adapter
//   Self-checking bench for reg_bus_adapter (AW=8, DW=32, NumRegs=16,
//   FullWriteOnly=1). Directed scenarios plus randomized accesses compared
//   against the adapter's rules computed directly in each test.
// -----------------------------------------------------------------------------
module tb_reg_bus_adapter;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        req_valid_i;
    logic        req_ready_o;
    logic        req_write_i;
    logic [7:0]  req_addr_i;
    logic [31:0] req_wdata_i;
    logic [3:0]  req_be_i;
    logic        rsp_valid_o;
    logic        rsp_ready_i;
    logic [31:0] rsp_rdata_o;
    logic        rsp_error_o;
    logic        reg_we_o;
    logic        reg_re_o;
    logic [7:0]  reg_addr_o;
    logic [31:0] reg_wdata_o;
    logic [3:0]  reg_be_o;
    logic [31:0] reg_rdata_i;
    logic        reg_error_i;

    int tests_run = 0;
    int failures  = 0;

    // Observations gathered by drive_access for the test tasks to judge.
    logic        obs_timeout;
    logic        obs_we;
    logic        obs_re;
    logic [7:0]  obs_addr;
    logic [31:0] obs_wdata;
    logic [3:0]  obs_be;
    logic        obs_valid_early;
    logic        obs_valid;
    logic [31:0] obs_rdata;
    logic        obs_err;
    logic        obs_unstable;
    logic        obs_stray_strobe;
    logic        obs_ready_busy;
    logic        obs_idle_ready;
    logic        obs_idle_valid;

    reg_bus_adapter #(
        .AW(8), .DW(32), .NumRegs(16), .FullWriteOnly(1'b1)
    ) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .req_write_i (req_write_i),
        .req_addr_i  (req_addr_i),
        .req_wdata_i (req_wdata_i),
        .req_be_i    (req_be_i),
        .rsp_valid_o (rsp_valid_o),
        .rsp_ready_i (rsp_ready_i),
        .rsp_rdata_o (rsp_rdata_o),
        .rsp_error_o (rsp_error_o),
        .reg_we_o    (reg_we_o),
        .reg_re_o    (reg_re_o),
        .reg_addr_o  (reg_addr_o),
        .reg_wdata_o (reg_wdata_o),
        .reg_be_o    (reg_be_o),
        .reg_rdata_i (reg_rdata_i),
        .reg_error_i (reg_error_i)
    );

    always #5 clk_i = ~clk_i;

    // Performs one complete access and records what the DUT did. Junk is
    // driven on the request and register-file inputs whenever the DUT should
    // be ignoring them.
    task automatic drive_access(input logic w, input logic [7:0] a, input logic [31:0] wd,
                                input logic [3:0] be, input logic [31:0] rd, input logic er,
                                input int hold);
        int n;
        obs_timeout = 0; obs_unstable = 0; obs_stray_strobe = 0; obs_ready_busy = 0;
        req_valid_i = 1'b1; req_write_i = w; req_addr_i = a; req_wdata_i = wd; req_be_i = be;
        reg_rdata_i = rd; reg_error_i = er; rsp_ready_i = 1'b0;
        n = 0;
        while (req_ready_o !== 1'b1 && n < 20) begin
            @(posedge clk_i); #1;
            n++;
        end
        if (n >= 20) begin
            obs_timeout = 1'b1;
            req_valid_i = 1'b0;
            return;
        end
        @(posedge clk_i); #1;
        req_write_i = ~w; req_addr_i = a ^ 8'h5A; req_wdata_i = ~wd; req_be_i = ~be;
        rsp_ready_i = 1'b1;
        obs_we = reg_we_o; obs_re = reg_re_o; obs_addr = reg_addr_o;
        obs_wdata = reg_wdata_o; obs_be = reg_be_o; obs_valid_early = rsp_valid_o;
        obs_ready_busy = req_ready_o;
        @(posedge clk_i); #1;
        obs_valid = rsp_valid_o; obs_rdata = rsp_rdata_o; obs_err = rsp_error_o;
        obs_ready_busy |= req_ready_o;
        obs_stray_strobe |= reg_we_o | reg_re_o;
        reg_rdata_i = ~rd; reg_error_i = ~er;
        rsp_ready_i = (hold == 0);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk_i); #1;
            if (rsp_valid_o !== 1'b1 || rsp_rdata_o !== obs_rdata || rsp_error_o !== obs_err ||
                reg_addr_o !== obs_addr || reg_wdata_o !== obs_wdata)
                obs_unstable = 1'b1;
            obs_ready_busy |= req_ready_o;
            obs_stray_strobe |= reg_we_o | reg_re_o;
            if (i == hold - 1) rsp_ready_i = 1'b1;
        end
        @(posedge clk_i); #1;
        obs_idle_ready = req_ready_o; obs_idle_valid = rsp_valid_o;
        obs_stray_strobe |= reg_we_o | reg_re_o;
        if (reg_addr_o !== obs_addr) obs_unstable = 1'b1;
        rsp_ready_i = 1'b0; req_valid_i = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        tests_run++;
        if (req_ready_o !== 1'b1 || rsp_valid_o !== 1'b0 || rsp_error_o !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_ctrl: ready=%b valid=%b err=%b, expected 1 0 0",
                     req_ready_o, rsp_valid_o, rsp_error_o);
        end
        tests_run++;
        if (reg_we_o !== 1'b0 || reg_re_o !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_strobes: we=%b re=%b, expected 0 0", reg_we_o, reg_re_o);
        end
        tests_run++;
        if (rsp_rdata_o !== 32'h0 || reg_addr_o !== 8'h0 || reg_wdata_o !== 32'h0 || reg_be_o !== 4'h0) begin
            failures++;
            $display("[TB] FAIL reset_data: rdata=%h addr=%h wdata=%h be=%h, expected all 0",
                     rsp_rdata_o, reg_addr_o, reg_wdata_o, reg_be_o);
        end
        @(negedge clk_i); rst_ni = 1'b1;
        @(posedge clk_i); #1;
    endtask

    task automatic test_read();
        drive_access(1'b0, 8'h0C, 32'h0, 4'hF, 32'hDEADBEEF, 1'b0, 0);
        tests_run++;
        if (obs_timeout || obs_re !== 1'b1 || obs_we !== 1'b0 || obs_addr !== 8'h0C) begin
            failures++;
            $display("[TB] FAIL read_strobe: to=%b re=%b we=%b addr=%h, expected 0 1 0 0c",
                     obs_timeout, obs_re, obs_we, obs_addr);
        end
        tests_run++;
        if (obs_valid_early !== 1'b0 || obs_valid !== 1'b1 || obs_rdata !== 32'hDEADBEEF || obs_err !== 1'b0) begin
            failures++;
            $display("[TB] FAIL read_resp: early=%b valid=%b rdata=%h err=%b, expected 0 1 deadbeef 0",
                     obs_valid_early, obs_valid, obs_rdata, obs_err);
        end
        tests_run++;
        if (obs_stray_strobe !== 1'b0 || obs_idle_ready !== 1'b1 || obs_idle_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL read_after: stray=%b ready=%b valid=%b, expected 0 1 0",
                     obs_stray_strobe, obs_idle_ready, obs_idle_valid);
        end
    endtask

    task automatic test_full_write();
        drive_access(1'b1, 8'h04, 32'h12345678, 4'hF, 32'hCAFEF00D, 1'b0, 1);
        tests_run++;
        if (obs_timeout || obs_we !== 1'b1 || obs_re !== 1'b0 || obs_wdata !== 32'h12345678 || obs_be !== 4'hF) begin
            failures++;
            $display("[TB] FAIL write_strobe: to=%b we=%b re=%b wdata=%h be=%h, expected 0 1 0 12345678 f",
                     obs_timeout, obs_we, obs_re, obs_wdata, obs_be);
        end
        tests_run++;
        if (obs_valid !== 1'b1 || obs_rdata !== 32'h0 || obs_err !== 1'b0 || obs_stray_strobe !== 1'b0) begin
            failures++;
            $display("[TB] FAIL write_resp: valid=%b rdata=%h err=%b stray=%b, expected 1 0 0 0",
                     obs_valid, obs_rdata, obs_err, obs_stray_strobe);
        end
    endtask

    task automatic test_error_paths();
        logic        ws [3] = '{1'b0, 1'b0, 1'b1};
        logic [7:0]  as [3] = '{8'h05, 8'h40, 8'h08};
        logic [3:0]  bs [3] = '{4'hF, 4'hF, 4'h3};
        for (int i = 0; i < 3; i++) begin
            drive_access(ws[i], as[i], 32'hA5A5A5A5, bs[i], 32'h11111111, 1'b0, 0);
            tests_run++;
            if (obs_timeout || obs_we !== 1'b0 || obs_re !== 1'b0 || obs_stray_strobe !== 1'b0) begin
                failures++;
                $display("[TB] FAIL err_nostrobe[%0d]: to=%b we=%b re=%b stray=%b, expected all 0",
                         i, obs_timeout, obs_we, obs_re, obs_stray_strobe);
            end
            tests_run++;
            if (obs_valid !== 1'b1 || obs_err !== 1'b1 || obs_rdata !== 32'h0) begin
                failures++;
                $display("[TB] FAIL err_resp[%0d]: valid=%b err=%b rdata=%h, expected 1 1 0",
                         i, obs_valid, obs_err, obs_rdata);
            end
        end
    endtask

    task automatic test_reg_error();
        drive_access(1'b1, 8'h3C, 32'h0BADF00D, 4'hF, 32'h0, 1'b1, 0);
        tests_run++;
        if (obs_timeout || obs_we !== 1'b1 || obs_err !== 1'b1 || obs_rdata !== 32'h0) begin
            failures++;
            $display("[TB] FAIL reg_error: to=%b we=%b err=%b rdata=%h, expected 0 1 1 0",
                     obs_timeout, obs_we, obs_err, obs_rdata);
        end
    endtask

    task automatic test_back_to_back();
        drive_access(1'b0, 8'h10, 32'h0, 4'hF, 32'h76543210, 1'b0, 5);
        tests_run++;
        if (obs_timeout || obs_unstable !== 1'b0 || obs_ready_busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL backpressure: to=%b unstable=%b ready_busy=%b, expected 0 0 0",
                     obs_timeout, obs_unstable, obs_ready_busy);
        end
        tests_run++;
        if (obs_rdata !== 32'h76543210 || obs_idle_ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL bp_resp: rdata=%h idle_ready=%b, expected 76543210 1",
                     obs_rdata, obs_idle_ready);
        end
    endtask

    task automatic test_random();
        for (int t = 0; t < 40; t++) begin
            logic        w;
            logic [7:0]  a;
            logic [31:0] wd, rd, exp_rdata;
            logic [3:0]  be;
            logic        er, bad, exp_err;
            w  = 1'($urandom_range(0, 1));
            a  = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 15) * 4);
            be = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'hF;
            wd = $urandom; rd = $urandom;
            er = ($urandom_range(0, 3) == 0);
            bad = (a % 4 != 0) || (a >= 64) || (w && be != 4'hF);
            exp_err = bad || er;
            exp_rdata = (!w && !exp_err) ? rd : 32'h0;
            drive_access(w, a, wd, be, rd, er, int'($urandom_range(0, 3)));
            tests_run++;
            if (obs_timeout || obs_we !== (w && !bad) || obs_re !== (!w && !bad) || obs_stray_strobe !== 1'b0) begin
                failures++;
                $display("[TB] FAIL rand_strobe[%0d]: to=%b we=%b re=%b stray=%b, expected 0 %b %b 0",
                         t, obs_timeout, obs_we, obs_re, obs_stray_strobe, w && !bad, !w && !bad);
            end
            tests_run++;
            if (obs_addr !== a || obs_wdata !== wd || obs_be !== be) begin
                failures++;
                $display("[TB] FAIL rand_capture[%0d]: addr=%h wdata=%h be=%h, expected %h %h %h",
                         t, obs_addr, obs_wdata, obs_be, a, wd, be);
            end
            tests_run++;
            if (obs_err !== exp_err || obs_rdata !== exp_rdata || obs_unstable !== 1'b0) begin
                failures++;
                $display("[TB] FAIL rand_resp[%0d]: err=%b rdata=%h unstable=%b, expected %b %h 0",
                         t, obs_err, obs_rdata, obs_unstable, exp_err, exp_rdata);
            end
        end
    endtask

    task automatic test_reset_mid_access();
        logic bad_after;
        int   n;
        n = 0;
        while (req_ready_o !== 1'b1 && n < 20) begin
            @(posedge clk_i); #1;
            n++;
        end
        req_valid_i = 1'b1; req_write_i = 1'b0; req_addr_i = 8'h20; req_be_i = 4'hF;
        reg_rdata_i = 32'h55AA55AA; reg_error_i = 1'b0;
        @(posedge clk_i); #1;
        req_valid_i = 1'b0;
        tests_run++;
        if (reg_re_o !== 1'b1) begin
            failures++;
            $display("[TB] FAIL midreset_pre: re=%b, expected 1", reg_re_o);
        end
        rst_ni = 1'b0;
        #1;
        tests_run++;
        if (reg_re_o !== 1'b0 || reg_we_o !== 1'b0 || rsp_valid_o !== 1'b0) begin
            failures++;
            $display("[TB] FAIL midreset_drop: re=%b we=%b valid=%b, expected 0 0 0",
                     reg_re_o, reg_we_o, rsp_valid_o);
        end
        @(negedge clk_i); rst_ni = 1'b1;
        bad_after = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk_i); #1;
            if (req_ready_o !== 1'b1 || rsp_valid_o !== 1'b0 || reg_re_o !== 1'b0 || reg_we_o !== 1'b0)
                bad_after = 1'b1;
        end
        tests_run++;
        if (bad_after !== 1'b0) begin
            failures++;
            $display("[TB] FAIL midreset_after: bad=%b, expected 0 (ready=1, idle outputs)", bad_after);
        end
    endtask

    initial begin
        rst_ni = 1'b0;
        req_valid_i = 1'b0; req_write_i = 1'b0; req_addr_i = '0; req_wdata_i = '0; req_be_i = '0;
        rsp_ready_i = 1'b0; reg_rdata_i = '0; reg_error_i = 1'b0;
        #12;
        test_reset();
        test_read();
        test_full_write();
        test_error_paths();
        test_reg_error();
        test_back_to_back();
        test_random();
        test_reset_mid_access();
        $display("[TB] %0d tests run, %0d failed", tests_run, failures);
        $finish;
    end

endmodule

// File: doc/reg_bus_adapter.md
Name: reg_bus_adapter

Overview:
- Bus-side front end of a register block.
- Converts a valid/ready request/response bus into single-cycle write strobes (`reg_we`/`reg_wd`) and read strobes (`reg_re`) for the per-field write arbiters. `reg_re` drives `we` of read-clear (RC) fields.
- Returns read data or an error on a buffered response channel.
- One access is in flight at a time. It sits between the crossbar/peripheral bus and the generated register file.

Parameters:
- AW, 8, byte-address width.
- DW, 32, data width (multiple of 8).
- NumRegs, 16, number of word registers implemented; valid byte addresses are 0 .. 4*NumRegs-1.
- FullWriteOnly, 1, if 1 any write with `req_be` != all-ones is rejected with an error.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  async active-low reset
- req_valid_i  in  1  request valid
- req_ready_o  out  1  request ready
- req_write_i  in  1  1=write, 0=read
- req_addr_i  in  AW  byte address
- req_wdata_i  in  DW  write data
- req_be_i  in  DW/8  byte enables
- rsp_valid_o  out  1  response valid
- rsp_ready_i  in  1  response ready
- rsp_rdata_o  out  DW  read data (0 for writes and errors)
- rsp_error_o  out  1  access error
- reg_we_o  out  1  one-cycle write strobe to register file
- reg_re_o  out  1  one-cycle read strobe (RC side effects)
- reg_addr_o  out  AW  captured address
- reg_wdata_o  out  DW  captured write data
- reg_be_o  out  DW/8  captured byte enables
- reg_rdata_i  in  DW  combinational read data for `reg_addr_o`
- reg_error_i  in  1  register-file error for `reg_addr_o` (e.g. write to RO)

Behaviour:
- Reset values:
  - state = IDLE.
  - `req_ready_o` = 1.
  - `rsp_valid_o`, `rsp_error_o`, `reg_we_o`, `reg_re_o` = 0.
  - `rsp_rdata_o`, `reg_addr_o`, `reg_wdata_o`, `reg_be_o` = 0.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - `req_ready_o` = 1.
  - On `req_valid_i` (handshake), capture write, addr, wdata and be. Compute `decode_err`:
    - addr[1:0] != 0, or
    - addr >= 4*NumRegs, or
    - (FullWriteOnly && write && be != all-ones).
  - Go to ACCESS.
- ACCESS (exactly one cycle):
  - `req_ready_o` = 0.
  - If !`decode_err`: assert `reg_we_o` (write) or `reg_re_o` (read) for this cycle only.
  - If `decode_err`: neither strobe is asserted; the register file sees no side effect.
  - Capture the response at the clock edge:
    - `rsp_error_o` = `decode_err` | `reg_error_i`.
    - `rsp_rdata_o` = `reg_rdata_i` only for an error-free read, else 0.
  - `reg_error_i` and `reg_rdata_i` are sampled only in ACCESS.
  - Go to RESP.
- RESP:
  - `rsp_valid_o` = 1; data and error are held stable until the handshake.
  - On `rsp_ready_i`, go to IDLE.
  - The next request cannot be accepted in the same cycle; `req_ready_o` = 0 in RESP.
- Latency and throughput:
  - Request handshake at cycle N; strobe at N+1; `rsp_valid_o` at N+2.
  - Minimum 3 cycles per access.
- `reg_addr_o`, `reg_wdata_o` and `reg_be_o` hold the last captured values outside ACCESS. They change only on request handshake.
- `reg_we_o` and `reg_re_o` are never both 1 and never 1 outside ACCESS.
- `req_*` inputs are ignored outside IDLE.
- `rsp_ready_i` is ignored outside RESP.
- Reset mid-operation: asynchronous return to reset values.
  - An access in ACCESS is abandoned with no strobe after the reset assertion.
  - A pending response is dropped.

Decomposition:
- Package `reg_bus_adapter_pkg` holds:
  - the state enum `rba_state_e` {IDLE, ACCESS, RESP};
  - the localparam helper for byte-enable width, DW/8.
- Natural sub-module: `reg_addr_check`, purely combinational.
  - Inputs: addr, write, be, plus the parameters.
  - Output: `decode_err`.
- Everything else stays in the top.

Test Plan:
- Read, NumRegs=16: addr 0x0C, `reg_rdata_i` = 0xDEADBEEF → `reg_re_o` high for one cycle at N+1 with `reg_addr_o` = 0x0C; response at N+2 with rdata 0xDEADBEEF, error 0.
- Full write: addr 0x04, wdata 0x12345678, be 0xF → `reg_we_o` one cycle with wdata 0x12345678; response error 0, rdata 0.
- Error paths, checking no strobe fires for each:
  - misaligned addr 0x05 → error 1;
  - addr 0x40 (out of range) → error 1;
  - FullWriteOnly=1, be 0x3 → error 1.
- Register-file error: `reg_error_i` = 1 during a write strobe → `reg_we_o` still pulses; response error 1.
- Backpressure: `rsp_ready_i` low for 5 cycles → `rsp_valid_o`, rdata and error stable; `req_ready_o` = 0 throughout; a second `req_valid_i` is not accepted until one cycle after the response handshake.
- Reset mid-access: assert `rst_ni` = 0 during ACCESS → `reg_re_o`/`reg_we_o` drop immediately, `rsp_valid_o` = 0, `req_ready_o` = 1 after release.
